// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM-stage access controller (master) and a
// variable-latency data memory (slave): req/ack handshake with byte enables.
interface mem_access_stage_if #(
  parameter int DATA_W = 64
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [7:0]        dmem_be;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// LEGv8 MEM-stage data-memory access controller: stalls the pipeline across a
// req/ack access. Optional macro ALIGN_CHECK_EN rejects misaligned dword ops.
module mem_access_stage #(
  parameter int MAX_WAIT = 16,
  parameter int DATA_W   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemRead_mem,
  input  logic                MemWrite_mem,
  input  logic                byte_mem,
  input  logic [DATA_W-1:0]   alu_result_mem,
  input  logic [DATA_W-1:0]   wr_data_mem,
  output logic [DATA_W-1:0]   dm_read_data_mem,
  output logic                stall_mem,
  output logic                bus_err,
  output logic                align_fault,
  mem_access_stage_if.master  dmem
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  state_t            state_r;
  logic [7:0]        wait_cnt_r;
  logic              is_read_r;
  logic              byte_r;
  logic [2:0]        off_r;
  logic              req_r;
  logic              we_r;
  logic [DATA_W-1:0] addr_r;
  logic [7:0]        be_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              bus_err_r;
  logic              align_fault_r;
  logic              op_s;
  logic              misalign_s;

  // Byte loads pick one lane and zero-extend; dword loads pass straight through.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] rdata,
                                                     input logic is_byte,
                                                     input logic [2:0] off);
    logic [DATA_W-1:0] shifted;
    shifted = rdata >> {off, 3'b000};
    if (is_byte) begin
      return {{(DATA_W-8){1'b0}}, shifted[7:0]};
    end else begin
      return rdata;
    end
  endfunction

  assign op_s = MemRead_mem | MemWrite_mem;

`ifdef ALIGN_CHECK_EN
  assign misalign_s = ~byte_mem & (alu_result_mem[2:0] != 3'b000);
`else
  assign misalign_s = 1'b0;
`endif

  // Access FSM with registered bus request, captured load data and fault pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= 8'd0;
      is_read_r     <= 1'b0;
      byte_r        <= 1'b0;
      off_r         <= 3'b000;
      req_r         <= 1'b0;
      we_r          <= 1'b0;
      addr_r        <= {DATA_W{1'b0}};
      be_r          <= 8'h00;
      wdata_r       <= {DATA_W{1'b0}};
      rdata_r       <= {DATA_W{1'b0}};
      bus_err_r     <= 1'b0;
      align_fault_r <= 1'b0;
    end else begin
      bus_err_r     <= 1'b0;
      align_fault_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (op_s) begin
            is_read_r  <= ~MemWrite_mem;
            byte_r     <= byte_mem;
            off_r      <= alu_result_mem[2:0];
            wait_cnt_r <= 8'd0;
            if (misalign_s) begin
              state_r       <= ST_DONE;
              rdata_r       <= {DATA_W{1'b0}};
              align_fault_r <= 1'b1;
            end else begin
              state_r <= ST_WAIT;
              req_r   <= 1'b1;
              we_r    <= MemWrite_mem;
              addr_r  <= {alu_result_mem[DATA_W-1:3], 3'b000};
              be_r    <= byte_mem ? (8'h01 << alu_result_mem[2:0]) : 8'hFF;
              wdata_r <= byte_mem ? {(DATA_W/8){wr_data_mem[7:0]}} : wr_data_mem;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // An ack on the final allowed cycle still completes normally.
          if (dmem.dmem_ack) begin
            state_r <= ST_DONE;
            req_r   <= 1'b0;
            if (is_read_r) begin
              rdata_r <= load_extract(dmem.dmem_rdata, byte_r, off_r);
            end else begin
              rdata_r <= rdata_r;
            end
          end else if (wait_cnt_r == LAST_CNT) begin
            state_r   <= ST_DONE;
            req_r     <= 1'b0;
            rdata_r   <= {DATA_W{1'b0}};
            bus_err_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  // Hold the pipeline from the cycle the op appears until the DONE cycle.
  always_comb begin
    stall_mem = 1'b0;
    case (state_r)
      ST_IDLE: stall_mem = op_s;
      ST_WAIT: stall_mem = 1'b1;
      ST_DONE: stall_mem = 1'b0;
      default: stall_mem = 1'b0;
    endcase
  end

  assign dm_read_data_mem = rdata_r;
  assign bus_err          = bus_err_r;
  assign align_fault      = align_fault_r;
  assign dmem.dmem_req    = req_r;
  assign dmem.dmem_we     = we_r;
  assign dmem.dmem_addr   = addr_r;
  assign dmem.dmem_be     = be_r;
  assign dmem.dmem_wdata  = wdata_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (default build; the
// alignment scenario adapts when ALIGN_CHECK_EN is defined).
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        MemRead_mem;
  logic        MemWrite_mem;
  logic        byte_mem;
  logic [63:0] alu_result_mem;
  logic [63:0] wr_data_mem;
  logic [63:0] dm_read_data_mem;
  logic        stall_mem;
  logic        bus_err;
  logic        align_fault;

  int checks;
  int failures;

  // Results of the most recent run_op call.
  int          r_stall;
  int          r_req;
  logic [7:0]  r_be;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_we;
  logic [63:0] r_result;
  logic        r_bus_err;
  logic        r_align;
  logic        r_done;
  logic        r_post_stall;
  logic        r_post_req;
  logic        r_post_err;

  mem_access_stage_if #(.DATA_W(64)) bus ();

  mem_access_stage #(.MAX_WAIT(16), .DATA_W(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .MemRead_mem      (MemRead_mem),
    .MemWrite_mem     (MemWrite_mem),
    .byte_mem         (byte_mem),
    .alu_result_mem   (alu_result_mem),
    .wr_data_mem      (wr_data_mem),
    .dm_read_data_mem (dm_read_data_mem),
    .stall_mem        (stall_mem),
    .bus_err          (bus_err),
    .align_fault      (align_fault),
    .dmem             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one memory op until the stall drops, acking on the ack_delay-th
  // request cycle (-1 = never), then removes the op for one cycle.
  task automatic run_op(input logic rd, input logic wr, input logic byt,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input int ack_delay, input logic [63:0] rdata);
    r_stall = 0; r_req = 0; r_done = 1'b0;
    r_be = 8'h00; r_addr = 64'h0; r_wdata = 64'h0; r_we = 1'b0;
    r_result = 64'h0; r_bus_err = 1'b0; r_align = 1'b0;
    @(negedge clk);
    MemRead_mem = rd; MemWrite_mem = wr; byte_mem = byt;
    alu_result_mem = addr; wr_data_mem = wdata; bus.dmem_ack = 1'b0;
    for (int i = 0; i < 200 && !r_done; i++) begin
      #1;
      if (stall_mem) begin
        r_stall++;
      end else begin
        r_done = 1'b1; r_result = dm_read_data_mem;
        r_bus_err = bus_err; r_align = align_fault;
      end
      if (bus.dmem_req) begin
        r_req++;
        r_be = bus.dmem_be; r_addr = bus.dmem_addr;
        r_wdata = bus.dmem_wdata; r_we = bus.dmem_we;
        if (r_req == ack_delay) begin
          bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata;
        end
      end
      if (!r_done) begin
        @(negedge clk);
        bus.dmem_ack = 1'b0;
      end
    end
    @(negedge clk);
    MemRead_mem = 1'b0; MemWrite_mem = 1'b0; byte_mem = 1'b0; bus.dmem_ack = 1'b0;
    #1;
    r_post_stall = stall_mem; r_post_req = bus.dmem_req; r_post_err = bus_err;
    checks++;
    if (r_done !== 1'b1) begin
      failures++; $display("FAIL op_timeout: stall never dropped got=%b exp=1", r_done);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({stall_mem, bus_err, align_fault, bus.dmem_req, bus.dmem_we} !== 5'b00000) begin
      failures++; $display("FAIL reset_ctl got=%b exp=00000",
        {stall_mem, bus_err, align_fault, bus.dmem_req, bus.dmem_we});
    end
    checks++;
    if ({bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, dm_read_data_mem} !== {64'h0, 8'h00, 64'h0, 64'h0}) begin
      failures++; $display("FAIL reset_data addr=%h be=%h wdata=%h rd=%h exp=all zero",
        bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, dm_read_data_mem);
    end
    // Non-memory instructions must not stall.
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (stall_mem !== 1'b0 || bus.dmem_req !== 1'b0) begin
      failures++; $display("FAIL nonmem_stall got=%b%b exp=00", stall_mem, bus.dmem_req);
    end
  endtask

  task automatic test_dword_load();
    run_op(1'b1, 1'b0, 1'b0, 64'h40, 64'h0, 1, 64'h1122334455667788);
    checks++;
    if (r_stall !== 2) begin
      failures++; $display("FAIL dload_stall got=%0d exp=2", r_stall);
    end
    checks++;
    if (r_be !== 8'hFF || r_addr !== 64'h40 || r_we !== 1'b0) begin
      failures++; $display("FAIL dload_req be=%h addr=%h we=%b exp=ff/40/0", r_be, r_addr, r_we);
    end
    checks++;
    if (r_result !== 64'h1122334455667788) begin
      failures++; $display("FAIL dload_data got=%h exp=1122334455667788", r_result);
    end
    checks++;
    if (r_post_stall !== 1'b0 || r_post_req !== 1'b0 || r_bus_err !== 1'b0) begin
      failures++; $display("FAIL dload_restart got=%b%b%b exp=000", r_post_stall, r_post_req, r_bus_err);
    end
  endtask

  task automatic test_byte_load();
    run_op(1'b1, 1'b0, 1'b1, 64'h43, 64'h0, 3, 64'hAABBCCDDEEFF0011);
    checks++;
    if (r_stall !== 4 || r_req !== 3) begin
      failures++; $display("FAIL bload_stall stall=%0d req=%0d exp=4/3", r_stall, r_req);
    end
    checks++;
    if (r_be !== 8'h08 || r_addr !== 64'h40) begin
      failures++; $display("FAIL bload_req be=%h addr=%h exp=08/40", r_be, r_addr);
    end
    checks++;
    if (r_result !== 64'h00000000000000EE) begin
      failures++; $display("FAIL bload_data got=%h exp=00000000000000ee", r_result);
    end
  endtask

  task automatic test_byte_store();
    run_op(1'b0, 1'b1, 1'b1, 64'h47, 64'h123456789ABCDE5A, 1, 64'hFFFFFFFFFFFFFFFF);
    checks++;
    if (r_we !== 1'b1 || r_be !== 8'h80 || r_addr !== 64'h40) begin
      failures++; $display("FAIL bstore_req we=%b be=%h addr=%h exp=1/80/40", r_we, r_be, r_addr);
    end
    checks++;
    if (r_wdata !== 64'h5A5A5A5A5A5A5A5A) begin
      failures++; $display("FAIL bstore_wdata got=%h exp=5a5a5a5a5a5a5a5a", r_wdata);
    end
    checks++;
    if (r_result !== 64'h00000000000000EE || r_stall !== 2) begin
      failures++; $display("FAIL bstore_keep rd=%h stall=%0d exp=ee/2", r_result, r_stall);
    end
  endtask

  task automatic test_dword_store_both();
    // Read and write both set: treated as a write; read data untouched.
    run_op(1'b1, 1'b1, 1'b0, 64'h18, 64'h0123456789ABCDEF, 2, 64'h5555555555555555);
    checks++;
    if (r_we !== 1'b1 || r_be !== 8'hFF || r_wdata !== 64'h0123456789ABCDEF || r_addr !== 64'h18) begin
      failures++; $display("FAIL dstore we=%b be=%h wd=%h addr=%h exp=1/ff/0123456789abcdef/18",
        r_we, r_be, r_wdata, r_addr);
    end
    checks++;
    if (r_result !== 64'h00000000000000EE) begin
      failures++; $display("FAIL dstore_keep got=%h exp=ee", r_result);
    end
  endtask

  task automatic test_timeout();
    run_op(1'b1, 1'b0, 1'b0, 64'h100, 64'h0, -1, 64'h0);
    checks++;
    if (r_req !== 16 || r_stall !== 17) begin
      failures++; $display("FAIL tmo_len req=%0d stall=%0d exp=16/17", r_req, r_stall);
    end
    checks++;
    if (r_bus_err !== 1'b1 || r_result !== 64'h0) begin
      failures++; $display("FAIL tmo_err err=%b rd=%h exp=1/0", r_bus_err, r_result);
    end
    checks++;
    if (r_post_err !== 1'b0 || r_post_stall !== 1'b0) begin
      failures++; $display("FAIL tmo_pulse err=%b stall=%b exp=0/0", r_post_err, r_post_stall);
    end
  endtask

  task automatic test_ack_at_limit();
    run_op(1'b1, 1'b0, 1'b0, 64'h200, 64'h0, 16, 64'hCAFEF00DDEADBEEF);
    checks++;
    if (r_bus_err !== 1'b0 || r_result !== 64'hCAFEF00DDEADBEEF || r_stall !== 17) begin
      failures++; $display("FAIL ack_limit err=%b rd=%h stall=%0d exp=0/cafef00ddeadbeef/17",
        r_bus_err, r_result, r_stall);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    MemRead_mem = 1'b1; alu_result_mem = 64'h80; bus.dmem_ack = 1'b0;
    @(negedge clk);   // first WAIT cycle
    @(negedge clk);   // second WAIT cycle
    #1;
    checks++;
    if (bus.dmem_req !== 1'b1) begin
      failures++; $display("FAIL rstw_pre req=%b exp=1", bus.dmem_req);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; MemRead_mem = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || stall_mem !== 1'b0 || dm_read_data_mem !== 64'h0 || bus_err !== 1'b0) begin
      failures++; $display("FAIL rstw_post req=%b stall=%b rd=%h err=%b exp=0/0/0/0",
        bus.dmem_req, stall_mem, dm_read_data_mem, bus_err);
    end
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'h7777777777777777;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || stall_mem !== 1'b0 || dm_read_data_mem !== 64'h0) begin
      failures++; $display("FAIL stray_ack req=%b stall=%b rd=%h exp=0/0/0",
        bus.dmem_req, stall_mem, dm_read_data_mem);
    end
  endtask

  task automatic test_align();
    run_op(1'b1, 1'b0, 1'b0, 64'h44, 64'h0, 1, 64'h0F0F0F0F0F0F0F0F);
`ifdef ALIGN_CHECK_EN
    checks++;
    if (r_req !== 0 || r_stall !== 1 || r_align !== 1'b1 || r_result !== 64'h0) begin
      failures++; $display("FAIL align req=%0d stall=%0d af=%b rd=%h exp=0/1/1/0",
        r_req, r_stall, r_align, r_result);
    end
`else
    checks++;
    if (r_req !== 1 || r_addr !== 64'h40 || r_be !== 8'hFF || r_align !== 1'b0 ||
        r_result !== 64'h0F0F0F0F0F0F0F0F) begin
      failures++; $display("FAIL align req=%0d addr=%h be=%h af=%b rd=%h exp=1/40/ff/0/0f0f0f0f0f0f0f0f",
        r_req, r_addr, r_be, r_align, r_result);
    end
`endif
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; MemRead_mem = 1'b0; MemWrite_mem = 1'b0; byte_mem = 1'b0;
    alu_result_mem = 64'h0; wr_data_mem = 64'h0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 64'h0;
    test_reset();
    test_dword_load();
    test_byte_load();
    test_byte_store();
    test_dword_store_both();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_wait();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
